// File: rtl/pri_request_latch.sv
// -----------------------------------------------------------------------------
// pri_request_latch
//
// Upstream companion to the 16-input priority encoder. Rising edges on the
// request lines are captured into sticky pending bits. The highest-index
// pending request that the mask allows is offered as a 4-bit index on a
// valid/ready handshake. A pending bit clears only when the consumer accepts
// its index, so no request is lost between detection and service.
//
// Ports:
//   clk           in   system clock, rising edge
//   reset_n       in   asynchronous active-low reset
//   req_in        in   [WIDTH]  request lines; a 0->1 transition is an event
//   mask          in   [WIDTH]  1 = line eligible for selection (all lines latch)
//   enable        in   1 = a new offer may start from IDLE
//   vec_out       out  [IDX_W]  offered request index
//   vec_valid     out  vec_out is valid
//   vec_ready     in   consumer accepts vec_out this cycle
//   pending_out   out  [WIDTH]  current pending register
//   overflow      out  sticky: an event arrived on a line that was already pending
//   overflow_clr  in   synchronous clear of overflow (a set in the same cycle wins)
//
// Build option:
//   PRI_REQUEST_LATCH_SYNC_EN  when defined, req_in passes through a 2-flop
//                              synchronizer before edge detection, which adds
//                              two cycles of latency (4 edges from req_in to
//                              vec_valid instead of 2).
// -----------------------------------------------------------------------------
module pri_request_latch #(
    parameter int WIDTH = 16,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] req_in,
    input  logic [WIDTH-1:0] mask,
    input  logic             enable,
    output logic [IDX_W-1:0] vec_out,
    output logic             vec_valid,
    input  logic             vec_ready,
    output logic [WIDTH-1:0] pending_out,
    output logic             overflow,
    input  logic             overflow_clr
);

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] req_s;      // request lines as seen by the edge detector
    logic [WIDTH-1:0] req_q;
    logic [WIDTH-1:0] pending_q;
    logic [WIDTH-1:0] pending_d;
    logic             overflow_q;
    logic             overflow_d;
    logic [IDX_W-1:0] vec_out_q;
    logic             vec_valid_q;

    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] clr_vec;
    logic [WIDTH-1:0] cand;
    logic [IDX_W-1:0] hi_idx;
    logic             accept;

`ifdef PRI_REQUEST_LATCH_SYNC_EN
    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= req_in;
            sync2_q <= sync1_q;
        end
    end

    assign req_s = sync2_q;
`else
    assign req_s = req_in;
`endif

    always_comb begin
        // NOTE: every signal assigned in this block gets a default first, so no
        // path through the if/for leaves a value unassigned and a latch inferred.
        clr_vec = '0;
        hi_idx  = '0;

        accept = vec_valid_q && vec_ready;
        if (accept) begin
            clr_vec[vec_out_q] = 1'b1;
        end

        rise = req_s & ~req_q;
        cand = pending_q & mask;

        // Ascending scan: the last set bit seen is the highest index.
        for (int i = 0; i < WIDTH; i++) begin
            if (cand[i]) begin
                hi_idx = IDX_W'(i);
            end
        end

        // Set wins over clear: a new rise on the line just accepted re-arms it.
        pending_d  = (pending_q & ~clr_vec) | rise;
        overflow_d = (overflow_q & ~overflow_clr) | (|(rise & pending_q & ~clr_vec));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples the pre-edge values regardless of statement order.
        if (!reset_n) begin
            state_q     <= IDLE;
            req_q       <= '0;
            pending_q   <= '0;
            overflow_q  <= 1'b0;
            vec_out_q   <= '0;
            vec_valid_q <= 1'b0;
        end else begin
            req_q      <= req_s;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;

            unique case (state_q)
                IDLE: begin
                    if (enable && (cand != '0)) begin
                        vec_out_q   <= hi_idx;
                        vec_valid_q <= 1'b1;
                        state_q     <= OFFER;
                    end
                end
                OFFER: begin
                    // The offer is never retracted; only acceptance ends it.
                    if (vec_ready) begin
                        vec_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    vec_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign vec_out     = vec_out_q;
    assign vec_valid   = vec_valid_q;
    assign pending_out = pending_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_pri_request_latch.sv
// -----------------------------------------------------------------------------
// tb_pri_request_latch
//
// Self-checking bench for pri_request_latch. Each vector holds the inputs for
// one clock cycle and the outputs expected just after the following rising
// edge. Expected outputs are queued when the inputs are driven and popped and
// compared #1 after the edge. Reset and reset-release corner cases are written
// out by hand. The build with PRI_REQUEST_LATCH_SYNC_EN runs a latency sequence
// for the synchronized path instead of the main table.
// -----------------------------------------------------------------------------
module tb_pri_request_latch;

    typedef struct {
        logic [15:0] req;
        logic [15:0] mask;
        logic        en;
        logic        rdy;
        logic        oclr;
        logic        e_valid;
        logic [3:0]  e_vec;
        logic [15:0] e_pend;
        logic        e_ovf;
    } vec_t;

    typedef struct {
        int          id;
        logic        e_valid;
        logic [3:0]  e_vec;
        logic [15:0] e_pend;
        logic        e_ovf;
    } exp_t;

    logic        clk;
    logic        reset_n;
    logic [15:0] req_in;
    logic [15:0] mask;
    logic        enable;
    logic [3:0]  vec_out;
    logic        vec_valid;
    logic        vec_ready;
    logic [15:0] pending_out;
    logic        overflow;
    logic        overflow_clr;

    int   n_applied;
    int   n_miss;
    int   n_step;
    vec_t tbl[$];
    exp_t exp_q[$];

    pri_request_latch #(
        .WIDTH(16),
        .IDX_W(4)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_in      (req_in),
        .mask        (mask),
        .enable      (enable),
        .vec_out     (vec_out),
        .vec_valid   (vec_valid),
        .vec_ready   (vec_ready),
        .pending_out (pending_out),
        .overflow    (overflow),
        .overflow_clr(overflow_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_applied++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic [15:0] req, input logic [15:0] msk, input logic en,
                       input logic rdy, input logic oclr, input logic e_valid,
                       input logic [3:0] e_vec, input logic [15:0] e_pend, input logic e_ovf);
        vec_t v;
        v.req = req; v.mask = msk; v.en = en; v.rdy = rdy; v.oclr = oclr;
        v.e_valid = e_valid; v.e_vec = e_vec; v.e_pend = e_pend; v.e_ovf = e_ovf;
        tbl.push_back(v);
    endtask

    // Drive one cycle of inputs, queue its expectation, clock, then compare.
    task automatic step(input vec_t v);
        exp_t e;
        exp_t got;
        req_in       = v.req;
        mask         = v.mask;
        enable       = v.en;
        vec_ready    = v.rdy;
        overflow_clr = v.oclr;
        e.id = n_step; e.e_valid = v.e_valid; e.e_vec = v.e_vec;
        e.e_pend = v.e_pend; e.e_ovf = v.e_ovf;
        exp_q.push_back(e);
        n_step++;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            n_applied++;
            n_miss++;
            $display("FAIL scoreboard: got empty queue, expected an entry");
        end else begin
            got = exp_q.pop_front();
            check($sformatf("s%0d.vec_valid", got.id), {31'd0, vec_valid}, {31'd0, got.e_valid});
            if (got.e_valid) begin
                check($sformatf("s%0d.vec_out", got.id), {28'd0, vec_out}, {28'd0, got.e_vec});
            end
            check($sformatf("s%0d.pending_out", got.id), {16'd0, pending_out}, {16'd0, got.e_pend});
            check($sformatf("s%0d.overflow", got.id), {31'd0, overflow}, {31'd0, got.e_ovf});
        end
    endtask

    task automatic step_args(input logic [15:0] req, input logic [15:0] msk, input logic en,
                             input logic rdy, input logic oclr, input logic e_valid,
                             input logic [3:0] e_vec, input logic [15:0] e_pend, input logic e_ovf);
        vec_t v;
        v.req = req; v.mask = msk; v.en = en; v.rdy = rdy; v.oclr = oclr;
        v.e_valid = e_valid; v.e_vec = e_vec; v.e_pend = e_pend; v.e_ovf = e_ovf;
        step(v);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".vec_valid"}, {31'd0, vec_valid}, 32'd0);
        check({tag, ".vec_out"}, {28'd0, vec_out}, 32'd0);
        check({tag, ".pending_out"}, {16'd0, pending_out}, 32'd0);
        check({tag, ".overflow"}, {31'd0, overflow}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_applied    = 0;
        n_miss       = 0;
        n_step       = 0;
        reset_n      = 1'b1;
        req_in       = '0;
        mask         = 16'hFFFF;
        enable       = 1'b1;
        vec_ready    = 1'b0;
        overflow_clr = 1'b0;

        #1 reset_n = 1'b0;
        #1 check_all_zero("reset");
        @(posedge clk);
        @(posedge clk);
        #1 reset_n = 1'b1;

`ifdef PRI_REQUEST_LATCH_SYNC_EN
        // Single-cycle pulse on line 5: valid appears after the 4th edge.
        step_args(16'h0020, 16'hFFFF, 1, 0, 0, 0, 4'd0, 16'h0000, 0);
        step_args(16'h0000, 16'hFFFF, 1, 0, 0, 0, 4'd0, 16'h0000, 0);
        step_args(16'h0000, 16'hFFFF, 1, 0, 0, 0, 4'd0, 16'h0020, 0);
        step_args(16'h0000, 16'hFFFF, 1, 0, 0, 1, 4'd5, 16'h0020, 0);
        step_args(16'h0000, 16'hFFFF, 1, 0, 0, 1, 4'd5, 16'h0020, 0);
        step_args(16'h0000, 16'hFFFF, 1, 1, 0, 0, 4'd0, 16'h0000, 0);
`else
        //   req       mask      en rdy clr  valid vec  pending   ovf
        // Single request on line 5, offer held until accepted.
        add(16'h0020, 16'hFFFF, 1, 0, 0,  0, 4'd0,  16'h0020, 0);
        add(16'h0000, 16'hFFFF, 1, 0, 0,  1, 4'd5,  16'h0020, 0);
        add(16'h0000, 16'hFFFF, 1, 0, 0,  1, 4'd5,  16'h0020, 0);
        add(16'h0000, 16'hFFFF, 1, 0, 0,  1, 4'd5,  16'h0020, 0);
        add(16'h0000, 16'hFFFF, 1, 1, 0,  0, 4'd0,  16'h0000, 0);
        add(16'h0000, 16'hFFFF, 1, 0, 0,  0, 4'd0,  16'h0000, 0);
        // Priority order 15, 10, 5, 0 with ready tied high.
        add(16'h8421, 16'hFFFF, 1, 1, 0,  0, 4'd0,  16'h8421, 0);
        add(16'h8421, 16'hFFFF, 1, 1, 0,  1, 4'd15, 16'h8421, 0);
        add(16'h0000, 16'hFFFF, 1, 1, 0,  0, 4'd0,  16'h0421, 0);
        add(16'h0000, 16'hFFFF, 1, 1, 0,  1, 4'd10, 16'h0421, 0);
        add(16'h0000, 16'hFFFF, 1, 1, 0,  0, 4'd0,  16'h0021, 0);
        add(16'h0000, 16'hFFFF, 1, 1, 0,  1, 4'd5,  16'h0021, 0);
        add(16'h0000, 16'hFFFF, 1, 1, 0,  0, 4'd0,  16'h0001, 0);
        add(16'h0000, 16'hFFFF, 1, 1, 0,  1, 4'd0,  16'h0001, 0);
        add(16'h0000, 16'hFFFF, 1, 1, 0,  0, 4'd0,  16'h0000, 0);
        add(16'h0000, 16'hFFFF, 1, 1, 0,  0, 4'd0,  16'h0000, 0);
        // Mask: only 3 offered, 12 waits until unmasked.
        add(16'h1008, 16'h00FF, 1, 1, 0,  0, 4'd0,  16'h1008, 0);
        add(16'h0000, 16'h00FF, 1, 1, 0,  1, 4'd3,  16'h1008, 0);
        add(16'h0000, 16'h00FF, 1, 1, 0,  0, 4'd0,  16'h1000, 0);
        add(16'h0000, 16'h00FF, 1, 1, 0,  0, 4'd0,  16'h1000, 0);
        add(16'h0000, 16'hFFFF, 1, 1, 0,  1, 4'd12, 16'h1000, 0);
        add(16'h0000, 16'hFFFF, 1, 1, 0,  0, 4'd0,  16'h0000, 0);
        // Enable low blocks offers; ready while not valid is ignored.
        add(16'h0002, 16'hFFFF, 0, 1, 0,  0, 4'd0,  16'h0002, 0);
        add(16'h0000, 16'hFFFF, 0, 1, 0,  0, 4'd0,  16'h0002, 0);
        add(16'h0000, 16'hFFFF, 0, 1, 0,  0, 4'd0,  16'h0002, 0);
        add(16'h0000, 16'hFFFF, 1, 0, 0,  1, 4'd1,  16'h0002, 0);
        add(16'h0000, 16'hFFFF, 1, 1, 0,  0, 4'd0,  16'h0000, 0);
        // Overflow on line 7, clear, set-wins-over-clear, accept-and-rise.
        add(16'h0080, 16'hFFFF, 1, 0, 0,  0, 4'd0,  16'h0080, 0);
        add(16'h0000, 16'hFFFF, 1, 0, 0,  1, 4'd7,  16'h0080, 0);
        add(16'h0080, 16'hFFFF, 1, 0, 0,  1, 4'd7,  16'h0080, 1);
        add(16'h0000, 16'hFFFF, 1, 0, 0,  1, 4'd7,  16'h0080, 1);
        add(16'h0000, 16'hFFFF, 1, 0, 1,  1, 4'd7,  16'h0080, 0);
        add(16'h0080, 16'hFFFF, 1, 0, 1,  1, 4'd7,  16'h0080, 1);
        add(16'h0000, 16'hFFFF, 1, 0, 1,  1, 4'd7,  16'h0080, 0);
        add(16'h0080, 16'hFFFF, 1, 1, 0,  0, 4'd0,  16'h0080, 0);
        add(16'h0000, 16'hFFFF, 1, 0, 0,  1, 4'd7,  16'h0080, 0);
        add(16'h0000, 16'hFFFF, 1, 1, 0,  0, 4'd0,  16'h0000, 0);
        add(16'h0000, 16'hFFFF, 1, 0, 0,  0, 4'd0,  16'h0000, 0);
        // Offer of 9 stays stable through mask/enable/pending changes.
        add(16'h0200, 16'hFFFF, 1, 0, 0,  0, 4'd0,  16'h0200, 0);
        add(16'h0000, 16'hFFFF, 1, 0, 0,  1, 4'd9,  16'h0200, 0);
        add(16'h4000, 16'h0000, 1, 0, 0,  1, 4'd9,  16'h4200, 0);
        add(16'h0000, 16'h0000, 0, 0, 0,  1, 4'd9,  16'h4200, 0);
        add(16'h0000, 16'h0000, 1, 1, 0,  0, 4'd0,  16'h4000, 0);
        add(16'h0000, 16'h0000, 1, 0, 0,  0, 4'd0,  16'h4000, 0);
        add(16'h0000, 16'hFFFF, 1, 0, 0,  1, 4'd14, 16'h4000, 0);
        add(16'h4000, 16'hFFFF, 1, 0, 0,  1, 4'd14, 16'h4000, 1);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i]);
        end

        // Reset mid-OFFER: all outputs drop without waiting for a clock edge.
        #1 reset_n = 1'b0;
        req_in = 16'h0004;
        #1 check_all_zero("async_reset");
        @(posedge clk);
        #1 reset_n = 1'b1;

        // Line 2 held high through reset release counts as exactly one event.
        step_args(16'h0004, 16'hFFFF, 1, 0, 0, 0, 4'd0, 16'h0004, 0);
        step_args(16'h0004, 16'hFFFF, 1, 1, 0, 1, 4'd2, 16'h0004, 0);
        step_args(16'h0004, 16'hFFFF, 1, 1, 0, 0, 4'd0, 16'h0000, 0);
        step_args(16'h0004, 16'hFFFF, 1, 1, 0, 0, 4'd0, 16'h0000, 0);
`endif

        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
        $finish;
    end

endmodule

// File: doc/pri_request_latch.md
Name: pri_request_latch

Overview:
- Upstream companion to the 16-input priority encoder.
- Captures rising edges on 16 request lines into sticky pending bits and applies a mask.
- Selects the highest-index pending, unmasked request and offers its 4-bit index on a valid/ready handshake.
- The pending bit clears only when the consumer accepts the index, so no request is lost between detection and service.

Parameters:
- WIDTH, 16, number of request lines (fixed at 16 for this revision; other values not supported).
- IDX_W, 4, index width, equal to log2(WIDTH).

Ports:
- clk  input  1  system clock, rising-edge.
- reset_n  input  1  asynchronous active-low reset.
- req_in  input  WIDTH  request lines; a 0->1 transition is an event.
- mask  input  WIDTH  1 = line eligible for selection; masked lines still latch.
- enable  input  1  1 = selection allowed from IDLE.
- vec_out  output  IDX_W  offered request index.
- vec_valid  output  1  vec_out is valid.
- vec_ready  input  1  consumer accepts vec_out this cycle.
- pending_out  output  WIDTH  current pending register.
- overflow  output  1  sticky flag: an event was lost on an already-pending line.
- overflow_clr  input  1  synchronous clear of overflow.

Behaviour:
- Reset (async assert, sync release): req_q=0, pending=0, vec_out=0, vec_valid=0, overflow=0, state=IDLE.
- Edge detect: req_q <= req_in; rise = req_in & ~req_q. A line held high from reset release counts as one event.
- Pending update each edge: pending <= (pending & ~clr_vec) | rise.
  - clr_vec is one-hot on vec_out when vec_valid && vec_ready, else 0.
  - Set wins: a rise on the line being cleared in the same cycle leaves the bit set.
- Overflow set when rise[i] && pending[i] && !clr_vec[i]. overflow_clr clears it; a simultaneous set wins.
- Candidate: cand = pending & mask; the selected index is the highest set bit of cand.
- FSM state IDLE:
  - vec_valid=0.
  - If enable && cand!=0: register vec_out=highest index, vec_valid=1, go to OFFER.
- FSM state OFFER:
  - vec_valid=1; vec_out held stable.
  - No retraction: changes to enable, mask or pending have no effect on the offer.
  - On vec_valid && vec_ready: clear the pending bit, vec_valid=0, go to IDLE.
- Latency:
  - req_in first sampled high at edge E0 -> pending bit visible after E0 -> vec_valid high after E1.
  - With vec_ready tied high, offers issue at most every 2 cycles.
- Index 0 is a legal vector (bit 0 request); vec_valid alone qualifies vec_out.
- When all requests are masked, pending bits accumulate and no offer is made; unmasking makes them eligible the next IDLE cycle.
- Reset mid-OFFER: offer dropped, all pending events lost, overflow cleared.
- vec_ready while vec_valid=0 is ignored.

Optional Feature:
- Macro: PRI_REQUEST_LATCH_SYNC_EN.
- Defined: req_in passes through a 2-flop synchronizer (reset to 0) before edge detection. Latency from req_in change to vec_valid becomes 4 edges.
- Undefined: req_in must be synchronous to clk; latency is 2 edges.

Test Plan:
- Single request: reset, mask=16'hFFFF, enable=1, vec_ready=0; pulse req_in[5] one cycle -> pending_out=16'h0020 after 1 edge; vec_valid=1 with vec_out=5 after 2 edges, held indefinitely; assert vec_ready one cycle -> pending_out=0 and vec_valid=0 next cycle.
- Priority order: req_in=16'h8421 rise together, vec_ready=1 -> vec_out sequence 15, 10, 5, 0 on successive offers, 2 cycles apart; pending_out ends 0.
- Mask and enable:
  - mask=16'h00FF, req_in[12] and req_in[3] pulse -> only 3 offered; pending_out=16'h1000 remains.
  - Set mask=16'hFFFF -> 12 offered.
  - enable=0 with pending -> no offer.
- Overflow and set-wins:
  - Pulse req_in[7] twice while 7 is pending and unaccepted -> overflow=1; overflow_clr -> 0.
  - A rise on 7 in the same cycle as acceptance of 7 -> pending[7] stays 1, overflow stays 0.
- Stability and reset: during OFFER of vec 9, change mask to 0 and raise req_in[14] -> vec_out stays 9 until accepted, then 14 is offered once mask is restored. Assert reset_n low mid-OFFER -> all outputs 0 asynchronously.
- With PRI_REQUEST_LATCH_SYNC_EN defined, repeat the single-request case -> vec_valid rises 4 edges after req_in rises.
